// File: rtl/seeg_axil_regs.sv
// ---------------------------------------------------------------------------
// seeg_axil_regs
//
// AXI4-Lite slave register bank for the sEEG top. The PS-side master uses it
// to configure the acquisition front end (enable, soft reset, per-line MISO
// delays). It also reads back a status word and a constant ID.
//
// Register map (byte offsets, only address bits [ADDR_WIDTH-1:2] decoded):
//   0x00 CTRL       RW  bit0 enable, bit1 soft reset (self-clearing, reads 0)
//   0x04 STATUS     RO  status_in, sampled when the read address is accepted
//   0x08 ID         RO  ID_VALUE
//   0x0C SCRATCH    RW  32-bit
//   0x78 MISO_DELAY RW  8 nibbles, nibble k = delay for MISO line k
//   other offsets:  write ignored / read 0, SLVERR response
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN   clock, asynchronous active-low reset
//   S_AXI_AW*/W*/B*             write address, data and response channels
//   S_AXI_AR*/R*                read address and data channels
//   ctrl_enable                 CTRL[0]
//   soft_reset                  one-cycle pulse when 1 is written to CTRL[1]
//   miso_delay                  MISO_DELAY register contents
//   miso_delay_upd              one-cycle pulse when MISO_DELAY is written
//   status_in                   live status word returned at STATUS
// ---------------------------------------------------------------------------
module seeg_axil_regs #(
  parameter int          ADDR_WIDTH       = 8,
  parameter logic [31:0] ID_VALUE         = 32'h5EE60001,
  parameter logic [31:0] MISO_DELAY_RESET = 32'h11111111
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]            S_AXI_AWPROT,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [31:0]           S_AXI_WDATA,
  input  logic [3:0]            S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]            S_AXI_ARPROT,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [31:0]           S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic                  ctrl_enable,
  output logic                  soft_reset,
  output logic [31:0]           miso_delay,
  output logic                  miso_delay_upd,
  input  logic [31:0]           status_in
);

  localparam logic [ADDR_WIDTH-1:0] OFF_CTRL    = ADDR_WIDTH'(32'h00);
  localparam logic [ADDR_WIDTH-1:0] OFF_STATUS  = ADDR_WIDTH'(32'h04);
  localparam logic [ADDR_WIDTH-1:0] OFF_ID      = ADDR_WIDTH'(32'h08);
  localparam logic [ADDR_WIDTH-1:0] OFF_SCRATCH = ADDR_WIDTH'(32'h0C);
  localparam logic [ADDR_WIDTH-1:0] OFF_MISO    = ADDR_WIDTH'(32'h78);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_COMMIT,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic awready_q, awready_d;
  logic wready_q, wready_d;
  logic arready_q, arready_d;

  logic [ADDR_WIDTH-3:0] aw_word_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic [1:0]            bresp_q;
  logic [31:0]           rdata_q;
  logic [1:0]            rresp_q;

  logic        ctrl_enable_q;
  logic        soft_reset_q;
  logic        miso_upd_q;
  logic [31:0] scratch_q;
  logic [31:0] miso_delay_q;

  logic                  aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0] wr_off, rd_off;
  logic [31:0]           wmask;
  logic [1:0]            wr_resp_d;
  logic [31:0]           rd_data_d;
  logic [1:0]            rd_resp_d;

  // Protection bits and the byte lane of the address carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_hs  = S_AXI_AWVALID && awready_q;
  assign w_hs   = S_AXI_WVALID && wready_q;
  assign ar_hs  = S_AXI_ARVALID && arready_q;
  assign commit = (wr_state_q == WR_COMMIT);

  assign wr_off = {aw_word_q, 2'b00};
  assign rd_off = {S_AXI_ARADDR[ADDR_WIDTH-1:2], 2'b00};
  assign wmask  = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}}, {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};

  // Write FSM state register. Ready flags are registered so they are low
  // throughout reset and only rise on the first edge after release.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_state_q <= WR_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
    end
  end

  // Write FSM next state: AW and W may arrive in either order or together;
  // a channel is ready only while nothing is held for it and no B is pending.
  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs && w_hs) wr_state_d = WR_COMMIT;
        else if (aw_hs)    wr_state_d = WR_HAVE_AW;
        else if (w_hs)     wr_state_d = WR_HAVE_W;
      end
      WR_HAVE_AW: if (w_hs)         wr_state_d = WR_COMMIT;
      WR_HAVE_W:  if (aw_hs)        wr_state_d = WR_COMMIT;
      WR_COMMIT:                    wr_state_d = WR_RESP;
      WR_RESP:    if (S_AXI_BREADY) wr_state_d = WR_IDLE;
      default:                      wr_state_d = WR_IDLE;
    endcase
    awready_d = (wr_state_d == WR_IDLE) || (wr_state_d == WR_HAVE_W);
    wready_d  = (wr_state_d == WR_IDLE) || (wr_state_d == WR_HAVE_AW);
  end

  // Write response decode: read-only registers accept and drop the write.
  always_comb begin
    wr_resp_d = RESP_SLVERR;
    case (wr_off)
      OFF_CTRL, OFF_STATUS, OFF_ID, OFF_SCRATCH, OFF_MISO: wr_resp_d = RESP_OKAY;
      default: wr_resp_d = RESP_SLVERR;
    endcase
  end

  // Captured write address/data, held until the commit edge.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_word_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (aw_hs) aw_word_q <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
    end
  end

  // Register file update on the commit edge. The pulse outputs default low
  // every cycle so they are high only in the cycle following a commit.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      ctrl_enable_q <= 1'b0;
      soft_reset_q  <= 1'b0;
      miso_upd_q    <= 1'b0;
      scratch_q     <= '0;
      miso_delay_q  <= MISO_DELAY_RESET;
      bresp_q       <= RESP_OKAY;
    end else begin
      soft_reset_q <= 1'b0;
      miso_upd_q   <= 1'b0;
      if (commit) begin
        bresp_q <= wr_resp_d;
        case (wr_off)
          OFF_CTRL: begin
            if (wstrb_q[0]) begin
              ctrl_enable_q <= wdata_q[0];
              soft_reset_q  <= wdata_q[1];
            end
          end
          OFF_SCRATCH: scratch_q <= (scratch_q & ~wmask) | (wdata_q & wmask);
          OFF_MISO: begin
            miso_delay_q <= (miso_delay_q & ~wmask) | (wdata_q & wmask);
            miso_upd_q   <= |wstrb_q;
          end
          default: ;
        endcase
      end
    end
  end

  // Read FSM state register.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
    end
  end

  // Read FSM next state: a single outstanding read.
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      RD_IDLE: if (ar_hs)        rd_state_d = RD_RESP;
      RD_RESP: if (S_AXI_RREADY) rd_state_d = RD_IDLE;
      default:                   rd_state_d = RD_IDLE;
    endcase
    arready_d = (rd_state_d == RD_IDLE);
  end

  // Read mux uses register values before any same-edge commit lands.
  always_comb begin
    rd_data_d = '0;
    rd_resp_d = RESP_OKAY;
    case (rd_off)
      OFF_CTRL:    rd_data_d = {31'b0, ctrl_enable_q};
      OFF_STATUS:  rd_data_d = status_in;
      OFF_ID:      rd_data_d = ID_VALUE;
      OFF_SCRATCH: rd_data_d = scratch_q;
      OFF_MISO:    rd_data_d = miso_delay_q;
      default:     rd_resp_d = RESP_SLVERR;
    endcase
  end

  // Read data is registered at the address handshake and held until taken.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_data_d;
      rresp_q <= rd_resp_d;
    end
  end

  assign S_AXI_AWREADY  = awready_q;
  assign S_AXI_WREADY   = wready_q;
  assign S_AXI_BVALID   = (wr_state_q == WR_RESP);
  assign S_AXI_BRESP    = bresp_q;
  assign S_AXI_ARREADY  = arready_q;
  assign S_AXI_RVALID   = (rd_state_q == RD_RESP);
  assign S_AXI_RDATA    = rdata_q;
  assign S_AXI_RRESP    = rresp_q;
  assign ctrl_enable    = ctrl_enable_q;
  assign soft_reset     = soft_reset_q;
  assign miso_delay     = miso_delay_q;
  assign miso_delay_upd = miso_upd_q;

endmodule

// File: tb/tb_seeg_axil_regs.sv
// ---------------------------------------------------------------------------
// tb_seeg_axil_regs
//
// Directed bench for seeg_axil_regs. A register-level model (plain variables
// updated per completed write) predicts the sideband outputs, which a compare
// process checks every falling edge; bus transactions check handshake timing
// and response values, with a few literal expectations pinning the model.
// ---------------------------------------------------------------------------
module tb_seeg_axil_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [7:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic        ctrlEnable, softReset, misoUpd;
  logic [31:0] misoDelay;
  logic [31:0] statusIn;

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 0;

  // Register-level model of the bank.
  logic        mEnable, mSoft, mUpd;
  logic [31:0] mScratch, mMiso;

  always #5 clk = ~clk;

  seeg_axil_regs dut (
    .S_AXI_ACLK     (clk),
    .S_AXI_ARESETN  (rst_n),
    .S_AXI_AWADDR   (awaddr),
    .S_AXI_AWPROT   (awprot),
    .S_AXI_AWVALID  (awvalid),
    .S_AXI_AWREADY  (awready),
    .S_AXI_WDATA    (wdata),
    .S_AXI_WSTRB    (wstrb),
    .S_AXI_WVALID   (wvalid),
    .S_AXI_WREADY   (wready),
    .S_AXI_BRESP    (bresp),
    .S_AXI_BVALID   (bvalid),
    .S_AXI_BREADY   (bready),
    .S_AXI_ARADDR   (araddr),
    .S_AXI_ARPROT   (arprot),
    .S_AXI_ARVALID  (arvalid),
    .S_AXI_ARREADY  (arready),
    .S_AXI_RDATA    (rdata),
    .S_AXI_RRESP    (rresp),
    .S_AXI_RVALID   (rvalid),
    .S_AXI_RREADY   (rready),
    .ctrl_enable    (ctrlEnable),
    .soft_reset     (softReset),
    .miso_delay     (misoDelay),
    .miso_delay_upd (misoUpd),
    .status_in      (statusIn)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Sideband outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("ctrl_enable", 32'(ctrlEnable), 32'(mEnable));
      checkOutput("soft_reset", 32'(softReset), 32'(mSoft));
      checkOutput("miso_delay", misoDelay, mMiso);
      checkOutput("miso_delay_upd", 32'(misoUpd), 32'(mUpd));
    end
  end

  function automatic void modelReset();
    mEnable  = 1'b0;
    mSoft    = 1'b0;
    mUpd     = 1'b0;
    mScratch = 32'h0;
    mMiso    = 32'h11111111;
  endfunction

  function automatic void modelWrite(input logic [7:0] addr, input logic [31:0] data,
                                     input logic [3:0] strb, output logic [1:0] resp);
    resp = 2'b00;
    case (addr & 8'hFC)
      8'h00: if (strb[0]) begin
        mEnable = data[0];
        mSoft   = data[1];
      end
      8'h04, 8'h08: ;
      8'h0C: for (int b = 0; b < 4; b++) if (strb[b]) mScratch[8*b +: 8] = data[8*b +: 8];
      8'h78: begin
        for (int b = 0; b < 4; b++) if (strb[b]) mMiso[8*b +: 8] = data[8*b +: 8];
        mUpd = (strb != 4'b0000);
      end
      default: resp = 2'b10;
    endcase
  endfunction

  function automatic void modelRead(input logic [7:0] addr, output logic [31:0] data,
                                    output logic [1:0] resp);
    resp = 2'b00;
    case (addr & 8'hFC)
      8'h00:   data = {31'b0, mEnable};
      8'h04:   data = statusIn;
      8'h08:   data = 32'h5EE60001;
      8'h0C:   data = mScratch;
      8'h78:   data = mMiso;
      default: begin data = 32'h0; resp = 2'b10; end
    endcase
  endfunction

  // One write transaction; AW/W are raised after awDelay/wDelay cycles and
  // BREADY is held low for hold cycles once the response appears.
  task automatic writeReg(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int awDelay, input int wDelay, input int hold);
    logic [1:0] expResp;
    logic awPend, wPend, awFire, wFire;
    int cyc;
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    awPend = 1'b1;
    wPend  = 1'b1;
    cyc    = 0;
    while ((awPend || wPend) && cyc < 40) begin
      awvalid = awPend && (cyc >= awDelay);
      wvalid  = wPend && (cyc >= wDelay);
      awFire  = awvalid && awready;
      wFire   = wvalid && wready;
      @(posedge clk); #1;
      if (awFire) awPend = 1'b0;
      if (wFire)  wPend  = 1'b0;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (awPend || wPend) begin
      checkOutput("wr_handshake_timeout", 32'(awPend || wPend), 32'h0);
      return;
    end
    checkOutput("bvalid_before_commit", 32'(bvalid), 32'h0);
    @(posedge clk); #1;
    modelWrite(addr, data, strb, expResp);
    bready = (hold == 0);
    checkOutput("bvalid_at_commit", 32'(bvalid), 32'h1);
    checkOutput("bresp", 32'(bresp), 32'(expResp));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      mSoft = 1'b0;
      mUpd  = 1'b0;
      checkOutput("bvalid_held", 32'(bvalid), 32'h1);
      checkOutput("bresp_held", 32'(bresp), 32'(expResp));
      checkOutput("awready_while_b", 32'(awready), 32'h0);
      checkOutput("wready_while_b", 32'(wready), 32'h0);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    mSoft  = 1'b0;
    mUpd   = 1'b0;
    checkOutput("bvalid_after_b", 32'(bvalid), 32'h0);
    checkOutput("awready_after_b", 32'(awready), 32'h1);
    checkOutput("wready_after_b", 32'(wready), 32'h1);
  endtask

  // One read transaction; status_in is disturbed right after the address is
  // accepted so the returned word must be the value sampled at acceptance.
  task automatic readReg(input logic [7:0] addr, input int hold,
                         output logic [31:0] got, output logic [1:0] gotResp);
    logic [31:0] expData;
    logic [1:0]  expResp;
    logic fire, fired;
    int cyc;
    modelRead(addr, expData, expResp);
    araddr  = addr;
    arvalid = 1'b1;
    fired   = 1'b0;
    cyc     = 0;
    got     = 32'h0;
    gotResp = 2'b00;
    while (!fired && cyc < 20) begin
      fire = arready;
      @(posedge clk); #1;
      if (fire) fired = 1'b1;
      cyc++;
    end
    arvalid = 1'b0;
    if (!fired) begin
      checkOutput("rd_handshake_timeout", 32'(fired), 32'h1);
      return;
    end
    statusIn = statusIn ^ 32'h0000FFFF;
    rready   = (hold == 0);
    got      = rdata;
    gotResp  = rresp;
    checkOutput("rvalid", 32'(rvalid), 32'h1);
    checkOutput("rdata", rdata, expData);
    checkOutput("rresp", 32'(rresp), 32'(expResp));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput("rvalid_held", 32'(rvalid), 32'h1);
      checkOutput("rdata_held", rdata, expData);
      checkOutput("rresp_held", 32'(rresp), 32'(expResp));
      checkOutput("arready_while_r", 32'(arready), 32'h0);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    checkOutput("rvalid_after_r", 32'(rvalid), 32'h0);
    checkOutput("arready_after_r", 32'(arready), 32'h1);
  endtask

  // Directed vector sequence.
  task automatic applyStimulus();
    logic [31:0] got;
    logic [1:0]  gotResp;
    int cyc;

    readReg(8'h78, 0, got, gotResp);
    checkOutput("lit_miso_reset_read", got, 32'h11111111);
    readReg(8'h08, 0, got, gotResp);
    checkOutput("lit_id_read", got, 32'h5EE60001);

    writeReg(8'h78, 32'h22222222, 4'hF, 0, 0, 0);
    checkOutput("lit_miso_out", misoDelay, 32'h22222222);
    readReg(8'h78, 0, got, gotResp);
    checkOutput("lit_miso_read", got, 32'h22222222);

    writeReg(8'h0C, 32'hAABBCCDD, 4'b0101, 3, 0, 0);
    readReg(8'h0C, 0, got, gotResp);
    checkOutput("lit_scratch_w_first", got, 32'h00BB00DD);
    writeReg(8'h0C, 32'h00000000, 4'hF, 0, 0, 0);
    writeReg(8'h0C, 32'hAABBCCDD, 4'b0101, 0, 2, 0);
    readReg(8'h0C, 0, got, gotResp);
    checkOutput("lit_scratch_aw_first", got, 32'h00BB00DD);

    writeReg(8'h0C, 32'h12345678, 4'hF, 0, 0, 5);
    readReg(8'h0C, 5, got, gotResp);
    checkOutput("lit_scratch_hold", got, 32'h12345678);

    writeReg(8'h00, 32'h00000003, 4'hF, 0, 0, 0);
    checkOutput("lit_ctrl_enable", 32'(ctrlEnable), 32'h1);
    readReg(8'h00, 0, got, gotResp);
    checkOutput("lit_ctrl_read", got, 32'h00000001);

    writeReg(8'h40, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    readReg(8'h40, 0, got, gotResp);
    checkOutput("lit_unmapped_data", got, 32'h0);
    checkOutput("lit_unmapped_resp", 32'(gotResp), 32'h2);

    writeReg(8'h78, 32'hDEADBEEF, 4'h0, 0, 0, 0);
    writeReg(8'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    readReg(8'h08, 0, got, gotResp);
    checkOutput("lit_id_after_write", got, 32'h5EE60001);

    statusIn = 32'hCAFE0042;
    readReg(8'h04, 0, got, gotResp);
    checkOutput("lit_status_sampled", got, 32'hCAFE0042);

    // Reset with AW accepted and W never sent.
    awaddr  = 8'h78;
    awvalid = 1'b1;
    cyc     = 0;
    while (!awready && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    checkOutput("awready_aw_held", 32'(awready), 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_bvalid", 32'(bvalid), 32'h0);
    checkOutput("rst_awready", 32'(awready), 32'h0);
    checkOutput("rst_wready", 32'(wready), 32'h0);
    checkOutput("lit_rst_miso", misoDelay, 32'h11111111);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("no_b_after_abort", 32'(bvalid), 32'h0);
    end
    writeReg(8'h78, 32'h33333333, 4'hF, 0, 0, 0);
    checkOutput("lit_miso_after_abort", misoDelay, 32'h33333333);
  endtask

  initial begin
    rst_n    = 1'b0;
    awaddr   = 8'h0;
    awprot   = 3'b000;
    awvalid  = 1'b0;
    wdata    = 32'h0;
    wstrb    = 4'h0;
    wvalid   = 1'b0;
    bready   = 1'b0;
    araddr   = 8'h0;
    arprot   = 3'b000;
    arvalid  = 1'b0;
    rready   = 1'b0;
    statusIn = 32'h00C0FFEE;
    modelReset();
    #2 checkEn = 1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_awready_init", 32'(awready), 32'h0);
    checkOutput("rst_wready_init", 32'(wready), 32'h0);
    checkOutput("rst_arready_init", 32'(arready), 32'h0);
    checkOutput("rst_bvalid_init", 32'(bvalid), 32'h0);
    checkOutput("rst_rvalid_init", 32'(rvalid), 32'h0);
    checkOutput("rst_rdata_init", rdata, 32'h0);
    checkOutput("rst_bresp_init", 32'(bresp), 32'h0);
    checkOutput("rst_rresp_init", 32'(rresp), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("awready_post_reset", 32'(awready), 32'h1);
    checkOutput("arready_post_reset", 32'(arready), 32'h1);
    applyStimulus();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
